// File: rtl/ethermac_tx_arbiter_pkg.sv
// ethermac_tx_arbiter_pkg
// Shared definitions for the ethermac transmit arbiter: default widths and
// limits, FSM state encoding and the frame-length legality check.
// No ports (package).
package ethermac_tx_arbiter_pkg;

  localparam int LEN_W          = 10;
  localparam int PKG_MAX_LENGTH = 757;
  localparam int DONE_TIMEOUT   = 4095;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_CHECK    = 3'd2,
    ST_WAIT_IDL = 3'd3,
    ST_IRQ      = 3'd4,
    ST_WAIT_DN  = 3'd5,
    ST_RELEASE  = 3'd6
  } arb_state_t;

  // A frame must carry at least one word and must fit the MAC buffer.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/ethermac_tx_arbiter_if.sv
// ethermac_tx_arbiter_if
// Bus between the transmit arbiter and the ethermac_send datapath.
//   o_mac_send_irq   arbiter -> MAC  1-cycle send request
//   o_mac_length     arbiter -> MAC  frame length in words
//   o_mac_data       arbiter -> MAC  word from the granted requester
//   i_mac_data_addr  MAC -> arbiter  buffer-fill word address
//   i_mac_send_dn    MAC -> arbiter  frame-complete pulse
//   i_mac_send_idl   MAC -> arbiter  MAC idle
// Modports: master (arbiter side), slave (MAC side).
interface ethermac_tx_arbiter_if #(
  parameter int LEN_W = ethermac_tx_arbiter_pkg::LEN_W
);

  logic             o_mac_send_irq;
  logic [LEN_W-1:0] o_mac_length;
  logic [15:0]      o_mac_data;
  logic [LEN_W-1:0] i_mac_data_addr;
  logic             i_mac_send_dn;
  logic             i_mac_send_idl;

  modport master (
    output o_mac_send_irq, o_mac_length, o_mac_data,
    input  i_mac_data_addr, i_mac_send_dn, i_mac_send_idl
  );

  modport slave (
    input  o_mac_send_irq, o_mac_length, o_mac_data,
    output i_mac_data_addr, i_mac_send_dn, i_mac_send_idl
  );

endinterface

// File: rtl/ethermac_tx_arbiter_rr_arbiter_ptr.sv
// rr_arbiter_ptr
// Combinational round-robin pick: first set bit of req at or after ptr,
// wrapping modulo NUM_REQ.
//   req    in   NUM_REQ  request vector
//   ptr    in   IDX_W    highest-priority index (always < NUM_REQ)
//   grant  out  NUM_REQ  one-hot winner, 0 if none
//   idx    out  IDX_W    winner index, 0 if none
//   any    out  1        at least one request present
module rr_arbiter_ptr #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int               j;
    logic [IDX_W-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ethermac_tx_arbiter.sv
// ethermac_tx_arbiter
// Shares one ethermac_send datapath between NUM_REQ frame sources with
// per-frame round-robin arbitration, length validation, a single-cycle send
// request, word steering from the winner and a send-done watchdog.
//   i_clk        in   1              clock
//   i_rst        in   1              synchronous reset, active-high
//   i_req        in   NUM_REQ        frame ready per requester
//   i_req_len    in   NUM_REQ*LEN_W  frame length per requester
//   i_req_data   in   NUM_REQ*16     word at o_rd_addr per requester
//   o_grant      out  NUM_REQ        one-hot MAC owner
//   o_rd_addr    out  LEN_W          requester buffer read address
//   o_done       out  NUM_REQ        1-cycle frame-sent pulse
//   o_err        out  NUM_REQ        1-cycle reject/timeout pulse
//   o_busy       out  1              not in IDLE
//   mac          ethermac_tx_arbiter_if.master  MAC-side bus
//
// state       | meaning
// IDLE        | no frame in flight, waiting for any request
// ARB         | pick round-robin winner, latch grant and length
// CHECK       | validate latched length, reject if illegal
// WAIT_IDL    | hold off until the MAC reports idle
// IRQ         | send request pulse is high, watchdog cleared
// WAIT_DN     | wait for send-done, watchdog counting
// RELEASE     | done/err pulse visible, drop grant, advance pointer
module ethermac_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int LEN_W          = ethermac_tx_arbiter_pkg::LEN_W,
  parameter int PKG_MAX_LENGTH = ethermac_tx_arbiter_pkg::PKG_MAX_LENGTH,
  parameter int DONE_TIMEOUT   = ethermac_tx_arbiter_pkg::DONE_TIMEOUT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
  input  logic [NUM_REQ*16-1:0]    i_req_data,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [LEN_W-1:0]         o_rd_addr,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [NUM_REQ-1:0]       o_err,
  output logic                     o_busy,
  ethermac_tx_arbiter_if.master    mac
);

  import ethermac_tx_arbiter_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [LEN_W-1:0]   len_q;
  logic               irq_q;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_arbiter_ptr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (i_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign o_rd_addr          = mac.i_mac_data_addr;
  assign mac.o_mac_length   = len_q;
  assign mac.o_mac_send_irq = irq_q;

  // gnt_idx keeps its last value after release, so the mux is gated by grant.
  always_comb begin
    mac.o_mac_data = '0;
    if (|o_grant) mac.o_mac_data = i_req_data[int'(gnt_idx)*16 +: 16];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      o_grant <= '0;
      len_q   <= '0;
      irq_q   <= 1'b0;
      cnt     <= '0;
      o_done  <= '0;
      o_err   <= '0;
      o_busy  <= 1'b0;
    end else begin
      irq_q  <= 1'b0;
      o_done <= '0;
      o_err  <= '0;
      case (state)
        ST_IDLE: begin
          if (|i_req) begin
            state  <= ST_ARB;
            o_busy <= 1'b1;
          end
        end
        ST_ARB: begin
          if (pick_any) begin
            o_grant <= pick_grant;
            gnt_idx <= pick_idx;
            len_q   <= i_req_len[int'(pick_idx)*LEN_W +: LEN_W];
            state   <= ST_CHECK;
          end else begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (!len_legal(32'(len_q), 32'(PKG_MAX_LENGTH))) begin
            o_err <= o_grant;
            state <= ST_RELEASE;
          end else begin
            state <= ST_WAIT_IDL;
          end
        end
        ST_WAIT_IDL: begin
          if (mac.i_mac_send_idl) begin
            irq_q <= 1'b1;
            state <= ST_IRQ;
          end
        end
        ST_IRQ: begin
          cnt   <= '0;
          state <= ST_WAIT_DN;
        end
        ST_WAIT_DN: begin
          cnt <= cnt + 1'b1;
          // done takes priority over a watchdog expiring in the same cycle
          if (mac.i_mac_send_dn) begin
            o_done <= o_grant;
            state  <= ST_RELEASE;
          end else if (cnt == CNT_W'(DONE_TIMEOUT - 1)) begin
            o_err <= o_grant;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          o_grant <= '0;
          ptr     <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state   <= ST_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          o_grant <= '0;
          state   <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ethermac_tx_arbiter.md
Name: ethermac_tx_arbiter

Overview:
Shares one ethermac_send transmit datapath between NUM_REQ frame sources (e.g. DHCP client, application, diagnostics). Round-robin arbitration per frame. Validates the frame length, fires the single-cycle send request, and steers the winner's 16-bit word stream into the MAC. Waits for send-done and reports per-requester completion or error, with a watchdog against a hung MAC.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LEN_W, 10, length/address width in 16-bit words
PKG_MAX_LENGTH, 757, largest legal frame length in words (matches MAC limit)
DONE_TIMEOUT, 4095, max cycles from send request to send-done before abort

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_req  in  NUM_REQ  frame-ready per requester; held until o_done/o_err bit
i_req_len  in  NUM_REQ*LEN_W  frame length per requester, slice k = bits [k*LEN_W +: LEN_W]
i_req_data  in  NUM_REQ*16  word at o_rd_addr from each requester buffer
o_grant  out  NUM_REQ  one-hot owner of the MAC
o_rd_addr  out  LEN_W  word address for requester buffers
o_done  out  NUM_REQ  1-cycle pulse: frame sent
o_err  out  NUM_REQ  1-cycle pulse: frame rejected or timed out
o_busy  out  1  arbiter not in IDLE
o_mac_send_irq  out  1  1-cycle send request to MAC
o_mac_length  out  LEN_W  latched frame length to MAC
o_mac_data  out  16  selected requester word to MAC
i_mac_data_addr  in  LEN_W  MAC buffer-fill address
i_mac_send_dn  in  1  MAC frame-complete pulse
i_mac_send_idl  in  1  MAC idle

Behaviour:
- Reset values:
  - o_grant=0, o_done=0, o_err=0, o_busy=0, o_mac_send_irq=0, o_mac_length=0.
  - Round-robin pointer=0, timeout counter=0, state IDLE.
- o_mac_data is a combinational mux of i_req_data by grant index; 0 when o_grant=0.
- o_rd_addr = i_mac_data_addr, combinational pass-through.
- FSM states: IDLE, ARB, CHECK, WAIT_IDL, IRQ, WAIT_DN, RELEASE.
- IDLE: if |i_req go ARB next cycle.
- ARB: pick the first requesting index at or after the pointer, wrapping modulo NUM_REQ. Register it into o_grant. Latch its length into o_mac_length. Go CHECK. If i_req has dropped to 0, return to IDLE.
- CHECK: if length==0 or length>PKG_MAX_LENGTH, pulse o_err[k] and go RELEASE. Else go WAIT_IDL.
- WAIT_IDL: wait for i_mac_send_idl=1, then go IRQ.
- IRQ: o_mac_send_irq=1 for exactly one cycle. Clear the timeout counter. Go WAIT_DN.
- WAIT_DN: count cycles.
  - i_mac_send_dn=1: pulse o_done[k], go RELEASE.
  - Counter reaches DONE_TIMEOUT first: pulse o_err[k], go RELEASE.
  - dn and timeout in the same cycle: dn wins.
- RELEASE:
  - o_grant=0; pointer = k+1 mod NUM_REQ.
  - Go IDLE, so each frame costs at least one idle cycle between grants.
- Latency: request in IDLE to o_mac_send_irq = 4 cycles when the MAC is idle (ARB, CHECK, WAIT_IDL, IRQ).
- o_mac_length and o_grant are stable from ARB through RELEASE; the MAC buffer fill uses them.
- Requester deasserting i_req after grant is ignored; the transfer completes and done/err is still pulsed.
- i_req bits are re-sampled only in ARB.
- A requester holding i_req after o_done is treated as a new frame and waits its round-robin turn.
- Spurious i_mac_send_dn outside WAIT_DN is ignored.
- Synchronous reset mid-frame:
  - All outputs return to reset values next cycle; no done/err pulse.
  - The MAC may finish its frame; the arbiter ignores the resulting dn.
- o_busy=1 in every state except IDLE.

Decomposition:
- Shared package (ethermac_pkg): FSM state encodings, PKG_MAX_LENGTH constant, LEN_W.
- One sub-module: rr_arbiter_ptr, a combinational round-robin priority pick. Inputs: req vector, pointer. Outputs: one-hot grant, index, any.

Test Plan:
- Single frame: i_req[1]=1, len=64, MAC idle → irq 4 cycles later, o_mac_length=64, o_grant=4'b0010, o_rd_addr tracks i_mac_data_addr, o_mac_data=req1 words. dn after 300 cycles → o_done[1] pulse, grant clears.
- Round-robin: all four i_req high continuously, len=32 each → grant order 0,1,2,3,0; each followed by its own o_done pulse.
- Length rejects:
  - len=0 on req2 → o_err[2] pulse, no irq.
  - len=758 → o_err pulse, no irq.
  - len=757 → irq issued.
- MAC busy: i_mac_send_idl=0 for 50 cycles after grant → irq held off, asserted the cycle after idl returns.
- Timeout: no dn after irq → o_err pulse at DONE_TIMEOUT cycles. dn and timeout in the same cycle → o_done only.
- Reset mid-WAIT_DN: i_rst for 1 cycle → all outputs 0 next cycle, pointer 0. A later dn produces no o_done.
